// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the shared 8x8 multiplier controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package approx_mul_pkg;

  localparam int OP_W     = 8;
  localparam int RES_W    = 16;
  // Requester index storage is sized for the largest supported NUM_REQ (8)
  localparam int ID_MAX_W = 3;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Operation payload captured at accept and carried through stage 1
  typedef struct packed {
    logic [OP_W-1:0]     x;
    logic [OP_W-1:0]     y;
    logic [ID_MAX_W-1:0] id;
    logic                mode;
  } stage_pld_t;

endpackage

// File: rtl/approx_mul8.sv
// Approximate 8x8 unsigned multiplier: partial products below column 4 are dropped.
// Latency: combinational.
// Backpressure: none (pure function of the operands).
module approx_mul8
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  output logic [RES_W-1:0] p_o
);

  localparam int TRUNC_COL = 4;

  // Sum only the partial-product bits that land in column TRUNC_COL or above
  always_comb begin
    p_o = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        if ((i + j >= TRUNC_COL) && a_i[i] && b_i[j]) begin
          p_o = p_o + (RES_W'(1) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/approx_mul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first active request at or above the pointer, wrapping.
// Latency: grant is combinational; pointer moves one cycle after an accept.
// Backpressure: pointer holds whenever no accept strobe is seen.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic               gnt_vld_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] cand;

  // Scan from farthest to nearest offset so the nearest active request wins
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

  // Next pointer is one past the winner, wrapping at NUM_REQ-1
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/approx_mul_share_ctrl.sv
// Shares one exact/approximate 8x8 multiplier among NUM_REQ round-robin requesters.
// Latency: 2 cycles accept-to-response; 1 op/cycle while resp_ready is high.
// Backpressure: S2 holds while resp_ready is low, S1 fills only when empty, then req_ready drops.
module approx_mul_share_ctrl
  import approx_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_x,
  input  logic [NUM_REQ*OP_W-1:0] req_y,
  input  logic [NUM_REQ-1:0]      mode_approx,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [RES_W-1:0]        resp_z,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_approx,
  output logic [CNT_W-1:0]        cnt_approx,
  output logic [CNT_W-1:0]        cnt_total,
  input  logic                    cnt_clr
);

  logic [OP_W-1:0] x_arr [NUM_REQ];
  logic [OP_W-1:0] y_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*OP_W +: OP_W];
    assign y_arr[gi] = req_y[gi*OP_W +: OP_W];
  end

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_idx;
  logic               adv1, adv2, accept;

  logic               v1_q, v1_d;
  stage_pld_t         s1_q, s1_d;
  logic               v2_q, v2_d;
  logic [RES_W-1:0]   z_q, z_d;
  logic [ID_MAX_W-1:0] id2_q, id2_d;
  logic               mode2_q, mode2_d;
  logic [CNT_W-1:0]   cnt_approx_q, cnt_approx_d;
  logic [CNT_W-1:0]   cnt_total_q, cnt_total_d;
  logic [RES_W-1:0]   z_approx, z_exact;

  assign adv2   = !v2_q || resp_ready;
  assign adv1   = !v1_q || adv2;
  // Gating with rst_n keeps req_ready low throughout reset
  assign accept = gnt_vld && adv1 && rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req_valid),
    .accept_i  (accept),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  approx_mul8 u_mul (
    .a_i (s1_q.x),
    .b_i (s1_q.y),
    .p_o (z_approx)
  );

  assign z_exact = RES_W'(s1_q.x) * RES_W'(s1_q.y);

  // Ready is offered only to the granted requester, and only when S1 can take it
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Stage next-state: S1 samples operands and mode at accept, S2 computes the product
  always_comb begin
    v1_d    = v1_q;
    s1_d    = s1_q;
    v2_d    = v2_q;
    z_d     = z_q;
    id2_d   = id2_q;
    mode2_d = mode2_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        s1_d.x    = x_arr[gnt_idx];
        s1_d.y    = y_arr[gnt_idx];
        s1_d.id   = ID_MAX_W'(gnt_idx);
        s1_d.mode = mode_approx[gnt_idx];
      end
    end
    if (adv2) begin
      v2_d    = v1_q;
      z_d     = (s1_q.mode == MODE_APPROX) ? z_approx : z_exact;
      id2_d   = s1_q.id;
      mode2_d = s1_q.mode;
    end
  end

  // Saturating profile counters; clear wins over a same-cycle accept
  always_comb begin
    cnt_total_d  = cnt_total_q;
    cnt_approx_d = cnt_approx_q;
    if (cnt_clr) begin
      cnt_total_d  = '0;
      cnt_approx_d = '0;
    end else if (accept) begin
      if (cnt_total_q != '1) cnt_total_d = cnt_total_q + 1'b1;
      if (mode_approx[gnt_idx] == MODE_APPROX && cnt_approx_q != '1) begin
        cnt_approx_d = cnt_approx_q + 1'b1;
      end
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      s1_q         <= '0;
      v2_q         <= 1'b0;
      z_q          <= '0;
      id2_q        <= '0;
      mode2_q      <= 1'b0;
      cnt_total_q  <= '0;
      cnt_approx_q <= '0;
    end else begin
      v1_q         <= v1_d;
      s1_q         <= s1_d;
      v2_q         <= v2_d;
      z_q          <= z_d;
      id2_q        <= id2_d;
      mode2_q      <= mode2_d;
      cnt_total_q  <= cnt_total_d;
      cnt_approx_q <= cnt_approx_d;
    end
  end

  assign resp_valid  = v2_q;
  assign resp_z      = z_q;
  assign resp_id     = id2_q[ID_W-1:0];
  assign resp_approx = mode2_q;
  assign cnt_total   = cnt_total_q;
  assign cnt_approx  = cnt_approx_q;

endmodule

// File: tb/tb_approx_mul_share_ctrl.sv
// Directed bench for approx_mul_share_ctrl (4 requesters, 4-bit counters).
// Latency: checks the 2-cycle accept-to-response timing.
// Backpressure: exercises stall, drain and counter saturation.
module tb_approx_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, mode_approx;
  logic [31:0] req_x, req_y;
  logic        resp_valid, resp_ready, resp_approx, cnt_clr;
  logic [15:0] resp_z;
  logic [1:0]  resp_id;
  logic [3:0]  cnt_approx, cnt_total;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  approx_mul_share_ctrl #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .mode_approx(mode_approx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
    .resp_id(resp_id), .resp_approx(resp_approx),
    .cnt_approx(cnt_approx), .cnt_total(cnt_total), .cnt_clr(cnt_clr)
  );

  // Issue one operation from requester r, scramble its inputs after accept,
  // and capture what the outputs show on the following two cycles.
  task automatic single_op(input int r, input logic m, input logic [7:0] x, input logic [7:0] y,
                           output logic [3:0] rdy, output logic rv1, output logic rv2,
                           output logic [15:0] z, output logic [1:0] id, output logic ap);
    @(negedge clk);
    resp_ready = 1'b1; req_valid = '0; req_valid[r] = 1'b1;
    mode_approx[r] = m; req_x[r*8 +: 8] = x; req_y[r*8 +: 8] = y;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = '0; mode_approx[r] = ~m; req_x[r*8 +: 8] = ~x; req_y[r*8 +: 8] = ~y;
    #1 rv1 = resp_valid;
    @(negedge clk);
    #1 rv2 = resp_valid; z = resp_z; id = resp_id; ap = resp_approx;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 4'hF; mode_approx = '0; resp_ready = 1'b1; cnt_clr = 1'b0;
    req_x = {8'd4, 8'd3, 8'd2, 8'd5}; req_y = {8'd1, 8'd1, 8'd1, 8'd7};
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_run++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    n_run++; if (resp_z !== 16'd0 || resp_id !== 2'd0 || resp_approx !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp got z=%0d id=%0d ap=%b exp 0/0/0", resp_z, resp_id, resp_approx); end
    n_run++; if (cnt_total !== 4'd0 || cnt_approx !== 4'd0) begin
      n_fail++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", cnt_total, cnt_approx); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_run++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat1_valid got %b exp 0", resp_valid); end
    @(negedge clk);
    #1;
    n_run++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_z !== 16'd35) begin
      n_fail++; $display("FAIL lat2_resp got v=%b id=%0d z=%0d exp 1/0/35", resp_valid, resp_id, resp_z); end
  endtask

  task automatic test_exact();
    logic [3:0] rdy; logic rv1, rv2, ap; logic [15:0] z; logic [1:0] id;
    single_op(2, 1'b0, 8'd200, 8'd100, rdy, rv1, rv2, z, id, ap);
    n_run++; if (rdy !== 4'b0100) begin n_fail++; $display("FAIL exact_ready got %b exp 0100", rdy); end
    n_run++; if (rv1 !== 1'b0 || rv2 !== 1'b1) begin n_fail++; $display("FAIL exact_latency got %b%b exp 01", rv1, rv2); end
    n_run++; if (z !== 16'd20000 || id !== 2'd2 || ap !== 1'b0) begin
      n_fail++; $display("FAIL exact_resp got z=%0d id=%0d ap=%b exp 20000/2/0", z, id, ap); end
  endtask

  task automatic test_approx_diff();
    logic [3:0] rdy; logic rv1, rv2, ap; logic [15:0] z; logic [1:0] id;
    single_op(1, 1'b1, 8'd3, 8'd3, rdy, rv1, rv2, z, id, ap);
    n_run++; if (rdy !== 4'b0010) begin n_fail++; $display("FAIL adiff_ready got %b exp 0010", rdy); end
    n_run++; if (rv2 !== 1'b1 || z !== 16'd0 || id !== 2'd1 || ap !== 1'b1) begin
      n_fail++; $display("FAIL adiff_resp got v=%b z=%0d id=%0d ap=%b exp 1/0/1/1", rv2, z, id, ap); end
  endtask

  task automatic test_approx_equal();
    logic [3:0] rdy; logic rv1, rv2, ap; logic [15:0] z; logic [1:0] id;
    single_op(1, 1'b1, 8'd64, 8'd2, rdy, rv1, rv2, z, id, ap);
    n_run++; if (rv2 !== 1'b1 || z !== 16'd128 || ap !== 1'b1) begin
      n_fail++; $display("FAIL aeq_resp got v=%b z=%0d ap=%b exp 1/128/1", rv2, z, ap); end
    n_run++; if (cnt_total !== 4'd4 || cnt_approx !== 4'd2) begin
      n_fail++; $display("FAIL cnt_mixed got %0d/%0d exp 4/2", cnt_total, cnt_approx); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; logic rv1, rv2, ap; logic [15:0] z; logic [1:0] id;
    logic [1:0] ids[$]; logic [15:0] zs[$];
    int acc = 0; int multi = 0;
    // Requester 3 moves the pointer back to 0
    single_op(3, 1'b0, 8'd1, 8'd1, rdy, rv1, rv2, z, id, ap);
    n_run++; if (id !== 2'd3 || z !== 16'd1) begin n_fail++; $display("FAIL rr_pre got id=%0d z=%0d exp 3/1", id, z); end
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    #1;
    n_run++; if (cnt_total !== 4'd0 || cnt_approx !== 4'd0) begin
      n_fail++; $display("FAIL clr got %0d/%0d exp 0/0", cnt_total, cnt_approx); end
    mode_approx = '0;
    for (int i = 0; i < 4; i++) begin req_x[i*8 +: 8] = 8'(10 + i); req_y[i*8 +: 8] = 8'd3; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      req_valid = (acc >= 8) ? 4'h0 : 4'hF;
      #1;
      if ($countones(req_ready) > 1) multi++;
      if (resp_valid) begin ids.push_back(resp_id); zs.push_back(resp_z); end
      if ((req_ready & req_valid) != 4'h0) acc++;
    end
    n_run++; if (acc != 8 || ids.size() != 8) begin
      n_fail++; $display("FAIL rr_count got acc=%0d resp=%0d exp 8/8", acc, ids.size()); end
    n_run++; if (multi != 0) begin n_fail++; $display("FAIL rr_onehot got %0d multi-ready cycles exp 0", multi); end
    for (int k = 0; k < ids.size() && k < 8; k++) begin
      n_run++; if (ids[k] !== 2'(k % 4) || zs[k] !== 16'((10 + k % 4) * 3)) begin
        n_fail++; $display("FAIL rr_seq[%0d] got id=%0d z=%0d exp %0d/%0d", k, ids[k], zs[k], k % 4, (10 + k % 4) * 3); end
    end
    n_run++; if (cnt_total !== 4'd8 || cnt_approx !== 4'd0) begin
      n_fail++; $display("FAIL rr_cnt got %0d/%0d exp 8/0", cnt_total, cnt_approx); end
  endtask

  task automatic test_backpressure();
    logic [1:0] ids[$]; logic [15:0] zs[$];
    logic [15:0] rec_z; logic [1:0] rec_id; logic seen = 1'b0;
    int acc = 0; int unstable = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 4'hF;
      #1;
      if ((req_ready & req_valid) != 4'h0) acc++;
      if (seen) begin
        if (!resp_valid || resp_z !== rec_z || resp_id !== rec_id || req_ready !== 4'h0) unstable++;
      end else if (resp_valid) begin
        seen = 1'b1; rec_z = resp_z; rec_id = resp_id;
      end
    end
    n_run++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts got %0d exp 2", acc); end
    n_run++; if (!seen || rec_id !== 2'd0 || rec_z !== 16'd30) begin
      n_fail++; $display("FAIL bp_head got seen=%b id=%0d z=%0d exp 1/0/30", seen, rec_id, rec_z); end
    n_run++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable cycles exp 0", unstable); end
    @(negedge clk);
    resp_ready = 1'b1; req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (resp_valid) begin ids.push_back(resp_id); zs.push_back(resp_z); end
      @(negedge clk);
    end
    n_run++; if (ids.size() != 2) begin n_fail++; $display("FAIL bp_drain_count got %0d exp 2", ids.size()); end
    for (int k = 0; k < ids.size() && k < 2; k++) begin
      n_run++; if (ids[k] !== 2'(k) || zs[k] !== 16'((10 + k) * 3)) begin
        n_fail++; $display("FAIL bp_drain[%0d] got id=%0d z=%0d exp %0d/%0d", k, ids[k], zs[k], k, (10 + k) * 3); end
    end
  endtask

  task automatic test_saturation();
    int acc = 0;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    mode_approx = 4'hF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req_valid = (acc >= 20) ? 4'h0 : 4'hF;
      #1;
      if ((req_ready & req_valid) != 4'h0) acc++;
    end
    n_run++; if (acc != 20) begin n_fail++; $display("FAIL sat_accepts got %0d exp 20", acc); end
    n_run++; if (cnt_approx !== 4'd15 || cnt_total !== 4'd15) begin
      n_fail++; $display("FAIL sat_cnt got %0d/%0d exp 15/15", cnt_approx, cnt_total); end
    @(negedge clk);
    req_valid = 4'b0001; cnt_clr = 1'b1;
    #1;
    n_run++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_accept_ready got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0; cnt_clr = 1'b0;
    #1;
    n_run++; if (cnt_approx !== 4'd0 || cnt_total !== 4'd0) begin
      n_fail++; $display("FAIL clr_priority got %0d/%0d exp 0/0", cnt_approx, cnt_total); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int leaked = 0;
    @(negedge clk);
    req_valid = 4'b0001; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0; rst_n = 1'b0;
    #1;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 if (resp_valid !== 1'b0) leaked++;
      @(negedge clk);
    end
    n_run++; if (leaked != 0) begin n_fail++; $display("FAIL midrst_leak got %0d response cycles exp 0", leaked); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx_diff();
    test_approx_equal();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mul_share_ctrl.md
Name: approx_mul_share_ctrl

Overview:
- Shares one 8x8 unsigned multiplier datapath among NUM_REQ requesters using round-robin arbitration.
- The datapath holds an approximate core (approx_mul8) and an exact product path; a per-requester mode bit chooses which one answers.
- Two-stage pipeline with valid/ready handshakes on both sides and full backpressure.
- Sits between accelerator lanes and the multiplier; it also counts approximate-mode operations for accuracy/energy profiling.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of the requester index, equal to clog2(NUM_REQ)
- CNT_W, 16, width of the saturating operation counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; high for at most one requester per cycle
- req_x  in  NUM_REQ*8  packed multiplicand operands; requester i uses bits [8i+7:8i]
- req_y  in  NUM_REQ*8  packed multiplier operands, same packing
- mode_approx  in  NUM_REQ  per-requester mode; 1 = approximate core, 0 = exact product
- resp_valid  out  1  result valid
- resp_ready  in  1  downstream accept
- resp_z  out  16  product
- resp_id  out  ID_W  index of the requester that issued the operation
- resp_approx  out  1  mode the operation was issued with
- cnt_approx  out  CNT_W  accepted approximate-mode operations, saturating
- cnt_total  out  CNT_W  accepted operations, saturating
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (async, rst_n=0):
  - all valid flags clear; resp_valid=0, resp_z=0, resp_id=0, resp_approx=0
  - cnt_approx=0, cnt_total=0
  - round-robin pointer=0
  - req_ready=0 while in reset
- Stage 1 (S1) register holds {v1, x, y, id, mode}.
- Stage 2 (S2) register holds {v2, z, id, mode}; S2 drives the resp_* ports directly.
- Advance conditions:
  - adv2 = !v2 | resp_ready
  - adv1 = !v1 | adv2
- Arbitration:
  - Grant goes to the first requester with req_valid=1, searching from the pointer upward and wrapping at NUM_REQ-1 back to 0.
  - req_ready[g] = adv1 for the granted requester g; 0 for all others.
  - Accept = req_valid[g] & req_ready[g]. On accept, S1 loads the operands and mode, and the pointer becomes (g+1) mod NUM_REQ.
  - With no accept, the pointer holds.
- Mode sampling: mode_approx[g] is sampled at accept only. A later change of mode_approx does not affect an operation already in flight.
- S1 to S2, when adv2 is high:
  - v2 = v1
  - z = mode ? approx_mul8(x,y) : x*y, 16-bit, no truncation
  - id and mode copy through
- Latency: result appears on resp_* 2 cycles after accept. Throughput is 1 op/cycle while resp_ready=1.
- Backpressure:
  - resp_valid=1 with resp_ready=0 holds S2 stable, with all resp_* outputs unchanged.
  - S1 refills only if it is empty. Once both stages are full, req_ready is all 0.
  - No operation is dropped or duplicated.
- Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,2,3,0,...
- Requester handshake rules:
  - A requester must hold its operands stable while valid and not yet accepted.
  - The controller does not depend on this for correctness; it samples operands only at accept.
- Counters:
  - On accept, cnt_total increments; cnt_approx increments if the sampled mode is 1.
  - Both counters saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr has priority over a same-cycle increment; the counter reads 0 on the next cycle.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is issued.

Decomposition:
- Shared package approx_mul_pkg holds:
  - operand width localparam OP_W=8 and result width RES_W=16
  - a struct for the stage payload {x, y, id, mode}
  - the MODE_EXACT/MODE_APPROX constants
- Sub-module rr_arbiter(NUM_REQ) provides:
  - combinational grant and grant index from the request vector and pointer
  - a pointer register that updates on an accept strobe
- approx_mul8 is the team's existing approximate 8x8 core, instantiated unchanged.

Test Plan:
1. Reset with pending requests, then release:
   - Stimulus: req_valid=4'b1111 while rst_n=0; release rst_n.
   - Required: req_ready=0 during reset; first grant on the first cycle after release goes to requester 0; resp_valid=0 until 2 cycles after the first accept.
2. Exact mode:
   - Stimulus: requester 2, mode=0, x=200, y=100.
   - Required: resp_z=20000, resp_id=2, resp_approx=0, exactly 2 cycles after accept.
3. Approximate mode, operands where the approximate result differs from exact:
   - Stimulus: requester 1, mode=1, x=3, y=3.
   - Required: resp_z=0, resp_approx=1.
4. Approximate mode, operands where the approximate result equals exact:
   - Stimulus: requester 1, mode=1, x=64, y=2.
   - Required: resp_z=128.
5. All four requesters continuously valid, resp_ready=1, 8 operations:
   - Required: resp_id sequence 0,1,2,3,0,1,2,3; cnt_total=8.
6. Backpressure:
   - Stimulus: resp_ready=0 for 5 cycles under continuous requests.
   - Required: only 2 operations accepted; resp_z/resp_id stable; after resp_ready=1, results drain in order with no loss.
7. Counter saturation and clear:
   - Stimulus: CNT_W=4, 20 approximate operations.
   - Required: cnt_approx=15. Then cnt_clr asserted in the same cycle as an accept gives cnt_approx=0 and cnt_total=0 on the next cycle.
